mem_block_responder: RTL and testbench

- Main-memory responder for the 2-way write-back cache's block refill/writeback interface.
- Accepts single-cycle mem_read / mem_write block requests and models a fixed access latency.
- Signals completion with a one-cycle mem_ready pulse and returns 128-bit blocks on data_from_mem.
- Sits between the cache and the backing store; used as the memory in the pipeline testbench and the top level.

---
 rtl/mem_block_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_block_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// mem_block_responder: main-memory model behind the 2-way write-back cache.
// Accepts one-cycle block read/write requests, waits a fixed LATENCY, then
// pulses mem_ready for one cycle. Reads return a 128-bit block on
// data_from_mem; writes commit to the array at the end of the DONE cycle.
// Optional feature macro: MEM_STATS_EN adds rd_count/wr_count outputs.
module mem_block_responder #(
  parameter int LATENCY         = 20,
  parameter int BLOCK_ADDR_BITS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_addr,
  input  logic [127:0] data_to_mem,
  output logic [127:0] data_from_mem,
  output logic         mem_ready,
  output logic         busy,
  output logic         proto_err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
`endif
);

  localparam int         DEPTH    = 1 << BLOCK_ADDR_BITS;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_stateNext;
  logic [7:0]                   r_cnt;
  logic [7:0]                   w_cntNext;
  logic [BLOCK_ADDR_BITS-1:0]   r_idx;
  logic                         r_isWrite;
  logic [127:0]                 r_wdata;
  logic [127:0]                 r_dataOut;
  logic                         r_protoErr;
  logic [127:0]                 r_mem [0:DEPTH-1];

  logic                         w_request;
  logic                         w_accept;
  logic [BLOCK_ADDR_BITS-1:0]   w_reqIdx;
  logic                         w_commit;
  logic                         w_nextIsRead;
  logic                         w_rdLoad;
  logic [BLOCK_ADDR_BITS-1:0]   w_rdIdx;
  logic                         w_fwd;
  logic                         w_protoViol;
  logic                         w_unusedAddr;

  assign w_reqIdx     = mem_addr[BLOCK_ADDR_BITS+3:4];
  assign w_unusedAddr = ^{mem_addr[31:BLOCK_ADDR_BITS+4], mem_addr[3:0]};

  // Next-state, counter and request/commit/forwarding decode
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_request    = mem_read | mem_write;
    w_accept     = 1'b0;
    w_nextIsRead = 1'b0;
    w_rdLoad     = 1'b0;
    w_rdIdx      = w_reqIdx;
    w_commit     = (r_state == DONE) && r_isWrite;
    w_fwd        = 1'b0;
    w_protoViol  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_accept = w_request;
        if (w_request) begin
          w_stateNext  = (LATENCY == 1) ? DONE : WAIT;
          w_cntNext    = CNT_LOAD;
          w_nextIsRead = ~mem_write;
          w_protoViol  = mem_read & mem_write;
        end else begin
          w_stateNext = IDLE;
          w_cntNext   = 8'd0;
        end
      end
      WAIT: begin
        w_cntNext    = r_cnt - 8'd1;
        w_nextIsRead = ~r_isWrite;
        w_rdIdx      = r_idx;
        w_protoViol  = w_request;
        if (r_cnt <= 8'd1) begin
          w_stateNext = DONE;
          w_cntNext   = 8'd0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = 8'd0;
      end
    endcase
    w_rdLoad = (w_stateNext == DONE) && w_nextIsRead;
    w_fwd    = w_commit && (r_idx == w_rdIdx);
  end

  // FSM state and latency counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Latch block index, op and write data of each accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_isWrite <= 1'b0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_idx     <= w_reqIdx;
      r_isWrite <= mem_write;
      r_wdata   <= data_to_mem;
    end
  end

  // Read data register, bypassing a write that commits on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut <= '0;
    end else if (w_rdLoad) begin
      r_dataOut <= w_fwd ? r_wdata : r_mem[w_rdIdx];
    end
  end

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_protoErr <= 1'b0;
    end else if (w_protoViol) begin
      r_protoErr <= 1'b1;
    end
  end

  // Storage array: not reset, written at the edge that ends a write's DONE
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign data_from_mem = r_dataOut;
  assign mem_ready     = (r_state == DONE);
  assign busy          = (r_state != IDLE);
  assign proto_err     = r_protoErr;

`ifdef MEM_STATS_EN
  logic [31:0] r_rdCount;
  logic [31:0] r_wrCount;

  // Completed-operation counters, one increment per DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdCount <= 32'd0;
      r_wrCount <= 32'd0;
    end else if (r_state == DONE) begin
      if (r_isWrite) begin
        r_wrCount <= r_wrCount + 32'd1;
      end else begin
        r_rdCount <= r_rdCount + 32'd1;
      end
    end
  end

  assign rd_count = r_rdCount;
  assign wr_count = r_wrCount;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: directed tests for mem_block_responder.
// dut runs at the default LATENCY=20, dut1 at LATENCY=1.
// Set MEM_STATS_EN to also check the rd_count/wr_count outputs.
module tb_mem_block_responder;

  localparam logic [127:0] PAT  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] BEEF = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;

  logic         clk;
  logic         reset;
  logic         memRead, memWrite;
  logic [31:0]  memAddr;
  logic [127:0] dataToMem, dataFromMem;
  logic         memReady, busy, protoErr;
  logic         memRead1, memWrite1;
  logic [31:0]  memAddr1;
  logic [127:0] dataToMem1, dataFromMem1;
  logic         memReady1, busy1, protoErr1;
`ifdef MEM_STATS_EN
  logic [31:0]  rdCount, wrCount, rdCount1, wrCount1;
`endif

  int passed = 0;
  int total  = 0;

  mem_block_responder dut (
    .clk(clk), .reset(reset),
    .mem_read(memRead), .mem_write(memWrite), .mem_addr(memAddr),
    .data_to_mem(dataToMem), .data_from_mem(dataFromMem),
    .mem_ready(memReady), .busy(busy), .proto_err(protoErr)
`ifdef MEM_STATS_EN
    , .rd_count(rdCount), .wr_count(wrCount)
`endif
  );

  mem_block_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .mem_read(memRead1), .mem_write(memWrite1), .mem_addr(memAddr1),
    .data_to_mem(dataToMem1), .data_from_mem(dataFromMem1),
    .mem_ready(memReady1), .busy(busy1), .proto_err(protoErr1)
`ifdef MEM_STATS_EN
    , .rd_count(rdCount1), .wr_count(wrCount1)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request in the current cycle (cycle 0); return the cycle of mem_ready or -1
  task automatic runRequest(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [127:0] data, output int readyCycle);
    int cyc;
    memRead = rd; memWrite = wr; memAddr = addr; dataToMem = data;
    tick();
    memRead = 1'b0; memWrite = 1'b0;
    cyc = 1;
    readyCycle = -1;
    while (cyc <= 60 && readyCycle < 0) begin
      if (memReady) readyCycle = cyc;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic runRequest1(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [127:0] data, output int readyCycle);
    int cyc;
    memRead1 = rd; memWrite1 = wr; memAddr1 = addr; dataToMem1 = data;
    tick();
    memRead1 = 1'b0; memWrite1 = 1'b0;
    cyc = 1;
    readyCycle = -1;
    while (cyc <= 10 && readyCycle < 0) begin
      if (memReady1) readyCycle = cyc;
      else begin
        tick();
        cyc++;
      end
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (memReady !== 1'b0) $display("[TB] FAIL reset_ready: got %b want 0", memReady); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (protoErr !== 1'b0) $display("[TB] FAIL reset_proto: got %b want 0", protoErr); else passed++;
    total++; if (dataFromMem !== 128'd0) $display("[TB] FAIL reset_data: got %h want 0", dataFromMem); else passed++;
    total++; if (dataFromMem1 !== 128'd0) $display("[TB] FAIL reset_data1: got %h want 0", dataFromMem1); else passed++;
`ifdef MEM_STATS_EN
    total++; if (rdCount !== 32'd0 || wrCount !== 32'd0)
      $display("[TB] FAIL reset_stats: got rd=%0d wr=%0d want 0/0", rdCount, wrCount); else passed++;
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    int rc;
    runRequest(1'b0, 1'b1, 32'h0000_0050, PAT, rc);
    total++; if (rc !== 20) $display("[TB] FAIL preload_latency: got %0d want 20", rc); else passed++;
    tick();
    memRead = 1'b1; memAddr = 32'h0000_0050;
    for (int c = 1; c <= 24; c++) begin
      tick();
      memRead = 1'b0;
      total++; if (memReady !== (c == 20))
        $display("[TB] FAIL read_ready_c%0d: got %b want %b", c, memReady, (c == 20)); else passed++;
      total++; if (busy !== (c <= 20))
        $display("[TB] FAIL read_busy_c%0d: got %b want %b", c, busy, (c <= 20)); else passed++;
      if (c >= 20) begin
        total++; if (dataFromMem !== PAT)
          $display("[TB] FAIL read_data_c%0d: got %h want %h", c, dataFromMem, PAT); else passed++;
      end
    end
  endtask

  task automatic test_write_read();
    int rc;
    runRequest(1'b0, 1'b1, 32'h0000_0ABC, BEEF, rc);
    total++; if (rc !== 20) $display("[TB] FAIL wr_latency: got %0d want 20", rc); else passed++;
    tick();
    runRequest(1'b1, 1'b0, 32'h0000_0AB0, 128'd0, rc);
    total++; if (rc !== 20) $display("[TB] FAIL rd_latency: got %0d want 20", rc); else passed++;
    total++; if (dataFromMem !== BEEF)
      $display("[TB] FAIL wr_rd_data: got %h want %h", dataFromMem, BEEF); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int rc;
    logic [127:0] valX, valY;
    valX = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    valY = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999;
    runRequest(1'b0, 1'b1, 32'h0000_2000, valY, rc);
    tick();
    runRequest(1'b0, 1'b1, 32'h0000_1000, valX, rc);
    total++; if (rc !== 20) $display("[TB] FAIL b2b_wr_latency: got %0d want 20", rc); else passed++;
    runRequest(1'b1, 1'b0, 32'h0000_2000, 128'd0, rc);
    total++; if (rc !== 20) $display("[TB] FAIL b2b_rd_latency: got %0d want 20 (cycle 40)", rc); else passed++;
    total++; if (dataFromMem !== valY)
      $display("[TB] FAIL b2b_rd_data: got %h want %h", dataFromMem, valY); else passed++;
    total++; if (protoErr !== 1'b0) $display("[TB] FAIL b2b_proto: got %b want 0", protoErr); else passed++;
    tick();
    runRequest(1'b1, 1'b0, 32'h0000_1000, 128'd0, rc);
    total++; if (dataFromMem !== valX)
      $display("[TB] FAIL b2b_wb_data: got %h want %h", dataFromMem, valX); else passed++;
    tick();
  endtask

  task automatic test_proto_wait();
    memRead = 1'b1; memAddr = 32'h0000_0050;
    for (int c = 1; c <= 25; c++) begin
      tick();
      memRead = (c == 7);
      total++; if (memReady !== (c == 20))
        $display("[TB] FAIL wait_ready_c%0d: got %b want %b", c, memReady, (c == 20)); else passed++;
      total++; if (protoErr !== (c >= 8))
        $display("[TB] FAIL wait_proto_c%0d: got %b want %b", c, protoErr, (c >= 8)); else passed++;
    end
    pulseReset();
    total++; if (protoErr !== 1'b0) $display("[TB] FAIL proto_clear: got %b want 0", protoErr); else passed++;
  endtask

  task automatic test_both_high();
    int rc;
    logic [127:0] valZ;
    valZ = 128'hFEED_FACE_0000_0000_0000_0000_CAFE_F00D;
    runRequest(1'b1, 1'b1, 32'h0000_0300, valZ, rc);
    total++; if (rc !== 20) $display("[TB] FAIL both_latency: got %0d want 20", rc); else passed++;
    total++; if (protoErr !== 1'b1) $display("[TB] FAIL both_proto: got %b want 1", protoErr); else passed++;
    tick();
    runRequest(1'b1, 1'b0, 32'h0000_0300, 128'd0, rc);
    total++; if (dataFromMem !== valZ)
      $display("[TB] FAIL both_data: got %h want %h", dataFromMem, valZ); else passed++;
    tick();
    pulseReset();
  endtask

  task automatic test_reset_mid();
    int rc;
    int pulses;
    logic [127:0] valOld, valNew;
    valOld = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
    valNew = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
    runRequest(1'b0, 1'b1, 32'h0000_0700, valOld, rc);
    tick();
    pulses = 0;
    memWrite = 1'b1; memAddr = 32'h0000_0700; dataToMem = valNew;
    for (int c = 1; c <= 30; c++) begin
      tick();
      memWrite = 1'b0;
      reset = (c == 10);
      if (memReady) pulses++;
      if (c == 11) begin
        total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else passed++;
      end
    end
    total++; if (pulses !== 0) $display("[TB] FAIL abort_ready: got %0d pulses want 0", pulses); else passed++;
    runRequest(1'b1, 1'b0, 32'h0000_0700, 128'd0, rc);
    total++; if (dataFromMem !== valOld)
      $display("[TB] FAIL abort_data: got %h want %h", dataFromMem, valOld); else passed++;
    tick();
  endtask

  task automatic test_alias();
    int rc;
    logic [127:0] valW;
    valW = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    runRequest(1'b0, 1'b1, 32'h0001_0050, valW, rc);
    tick();
    runRequest(1'b1, 1'b0, 32'hFFFF_0058, 128'd0, rc);
    total++; if (dataFromMem !== valW)
      $display("[TB] FAIL alias_data: got %h want %h", dataFromMem, valW); else passed++;
    tick();
  endtask

  task automatic test_latency1();
    int rc;
    logic [127:0] valQ, valR;
    valQ = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    valR = 128'h4444_0000_4444_0000_4444_0000_4444_0000;
    pulseReset();
    runRequest1(1'b0, 1'b1, 32'h0000_0030, valQ, rc);
    total++; if (rc !== 1) $display("[TB] FAIL l1_wr_latency: got %0d want 1", rc); else passed++;
    tick();
    runRequest1(1'b1, 1'b0, 32'h0000_0030, 128'd0, rc);
    total++; if (rc !== 1) $display("[TB] FAIL l1_rd_latency: got %0d want 1", rc); else passed++;
    total++; if (dataFromMem1 !== valQ)
      $display("[TB] FAIL l1_rd_data: got %h want %h", dataFromMem1, valQ); else passed++;
    tick();
    total++; if (busy1 !== 1'b0) $display("[TB] FAIL l1_idle_busy: got %b want 0", busy1); else passed++;
`ifdef MEM_STATS_EN
    total++; if (rdCount1 !== 32'd1) $display("[TB] FAIL l1_rd_count: got %0d want 1", rdCount1); else passed++;
    total++; if (wrCount1 !== 32'd1) $display("[TB] FAIL l1_wr_count: got %0d want 1", wrCount1); else passed++;
`endif
    runRequest1(1'b0, 1'b1, 32'h0000_0040, valR, rc);
    runRequest1(1'b1, 1'b0, 32'h0000_0040, 128'd0, rc);
    total++; if (rc !== 1) $display("[TB] FAIL l1_fwd_latency: got %0d want 1", rc); else passed++;
    total++; if (dataFromMem1 !== valR)
      $display("[TB] FAIL l1_fwd_data: got %h want %h", dataFromMem1, valR); else passed++;
    total++; if (protoErr1 !== 1'b0) $display("[TB] FAIL l1_proto: got %b want 0", protoErr1); else passed++;
    tick();
`ifdef MEM_STATS_EN
    total++; if (rdCount1 !== 32'd2 || wrCount1 !== 32'd2)
      $display("[TB] FAIL l1_counts: got rd=%0d wr=%0d want 2/2", rdCount1, wrCount1); else passed++;
`endif
  endtask

  // Run every scenario in order, then report
  initial begin
    reset = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; memAddr = 32'd0; dataToMem = 128'd0;
    memRead1 = 1'b0; memWrite1 = 1'b0; memAddr1 = 32'd0; dataToMem1 = 128'd0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_proto_wait();
    test_both_high();
    test_reset_mid();
    test_alias();
    test_latency1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
